// File: rtl/ising_ctrl_pkg.sv
// Shared types and constants for the Ising array run controller.
// Register map indices, CTRL bit positions and the run FSM state encoding.
package ising_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    RUN,
    SYNC,
    DONE
  } state_e;

  localparam logic [1:0] REG_CTRL       = 2'd0;
  localparam logic [1:0] REG_STATUS     = 2'd1;
  localparam logic [1:0] REG_RUN_CYCLES = 2'd2;
  localparam logic [1:0] REG_RESULT     = 2'd3;

  localparam int CTRL_GO     = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int SYNC_CYCLES = 2;

endpackage

// File: rtl/ising_run_ctrl_spin_sync.sv
// Two-flop synchronizer bringing the asynchronous cell spin outputs
// into the controller clock domain.
module spin_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ising_run_ctrl.sv
// Anneal run sequencer for the coupled-cell Ising array: settle, run, sync, capture.
// Optional `ISING_CTRL_IRQ_EN adds an irq output and CTRL IRQ_ENABLE bit.
module ising_run_ctrl
  import ising_ctrl_pkg::*;
#(
  parameter int NUM_SPINS     = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wready,
  input  logic [3:0]           waddr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           raddr,
  output logic [31:0]          rdata,
  input  logic [NUM_SPINS-1:0] spins_in,
  output logic                 ising_rstn,
  output logic                 start,
  output logic                 busy,
  output logic                 done
`ifdef ISING_CTRL_IRQ_EN
  ,
  output logic                 irq
`endif
);

  state_e                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [31:0]           run_cycles_q;
  logic [31:0]           run_load;
  logic [NUM_SPINS-1:0]  result_q;
  logic [NUM_SPINS-1:0]  spins_sync;
  logic                  rstn_q, start_q, busy_q, done_q;
  logic                  irq_en_q;
  logic                  wr_ctrl, wr_run, go, abort, capture;
  logic                  unused_addr;

  assign unused_addr = ^{waddr[1:0], raddr[1:0]};

  spin_sync #(.W(NUM_SPINS)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (spins_in),
    .q_o (spins_sync)
  );

  assign wr_ctrl  = wready && (waddr[3:2] == REG_CTRL);
  assign wr_run   = wready && (waddr[3:2] == REG_RUN_CYCLES);
  assign go       = wr_ctrl && wdata[CTRL_GO];
  assign abort    = wr_ctrl && wdata[CTRL_ABORT];
  assign run_load = (run_cycles_q == '0) ? 32'd1 : run_cycles_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (go) begin
            state_d = SETTLE;
            cnt_d   = 32'(SETTLE_CYCLES);
          end
        end
        SETTLE: begin
          if (cnt_q == 32'd1) begin
            state_d = RUN;
            cnt_d   = run_load;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        RUN: begin
          if (cnt_q == 32'd1) begin
            state_d = SYNC;
            cnt_d   = 32'(SYNC_CYCLES);
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        SYNC: begin
          if (cnt_q == 32'd1) begin
            state_d = DONE;
            capture = 1'b1;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they change with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      run_cycles_q <= '0;
      result_q     <= '0;
      rstn_q       <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      irq_en_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rstn_q  <= state_d inside {SETTLE, RUN, SYNC};
      busy_q  <= state_d inside {SETTLE, RUN, SYNC};
      start_q <= state_d inside {RUN, SYNC};
      done_q  <= (state_d == DONE);
      if (wr_run) run_cycles_q <= wdata;
      if (capture) result_q <= spins_sync;
`ifdef ISING_CTRL_IRQ_EN
      if (wr_ctrl) irq_en_q <= wdata[CTRL_IRQ_EN];
`endif
    end
  end

`ifdef ISING_CTRL_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= capture && !abort && irq_en_q;
  end

  assign irq = irq_q;
`endif

  always_comb begin
    rdata = '0;
    unique case (raddr[3:2])
      REG_CTRL:       rdata[CTRL_IRQ_EN] = irq_en_q;
      REG_STATUS:     rdata[1:0] = {done_q, busy_q};
      REG_RUN_CYCLES: rdata = run_cycles_q;
      REG_RESULT:     rdata[NUM_SPINS-1:0] = result_q;
      default:        rdata = '0;
    endcase
  end

  assign ising_rstn = rstn_q;
  assign start      = start_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Directed scoreboard bench for ising_run_ctrl (SETTLE_CYCLES=4, NUM_SPINS=8).
// Expected run timing/results are queued at GO and checked when done rises.
module tb_ising_run_ctrl;

  localparam int NS = 8;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wready;
  logic [3:0]    waddr;
  logic [31:0]   wdata;
  logic [3:0]    raddr;
  logic [31:0]   rdata;
  logic [NS-1:0] spins_in;
  logic          ising_rstn, start, busy, done;
`ifdef ISING_CTRL_IRQ_EN
  logic          irq;
`endif

  ising_run_ctrl #(.NUM_SPINS(NS), .SETTLE_CYCLES(SC)) dut (
    .clk        (clk),
    .rst        (rst),
    .wready     (wready),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr      (raddr),
    .rdata      (rdata),
    .spins_in   (spins_in),
    .ising_rstn (ising_rstn),
    .start      (start),
    .busy       (busy),
    .done       (done)
`ifdef ISING_CTRL_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    int          hi;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   start_hi = 0;
  int   lat;

  always @(negedge clk) if (start === 1'b1) start_hi++;

`ifdef ISING_CTRL_IRQ_EN
  int   irq_cnt = 0;
  int   irq_bad = 0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (irq === 1'b1) begin
      irq_cnt++;
      if (!(done === 1'b1 && done_prev === 1'b0)) irq_bad++;
    end
    done_prev = done;
  end
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    @(negedge clk);
    wready = 1'b1;
    waddr  = {r, 2'b00};
    wdata  = d;
    @(posedge clk);
    #1;
    wready = 1'b0;
  endtask

  task automatic rd(input logic [1:0] r, input logic [31:0] exp,
                    input string tag);
    raddr = {r, 2'b00};
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic wait_done();
    while (done !== 1'b1 && lat < 300) step(1);
  endtask

  function automatic int eff(input int rc);
    return (rc == 0) ? 1 : rc;
  endfunction

  task automatic push_exp(input int rc, input logic [31:0] sp);
    exp_t e;
    e.lat = SC + eff(rc) + 2;
    e.hi  = eff(rc) + 2;
    e.res = sp;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "_lat"}, lat, e.lat);
    chk({tag, "_start_hi"}, start_hi, e.hi);
    rd(2'd3, e.res, {tag, "_result"});
    rd(2'd1, 32'h2, {tag, "_status"});
  endtask

  task automatic run_check(input int rc, input logic [NS-1:0] sp,
                           input logic [31:0] cmd, input string tag);
    spins_in = sp;
    wr(2'd2, rc);
    push_exp(rc, 32'(sp));
    start_hi = 0;
    wr(2'd0, cmd);
    lat = 0;
    wait_done();
    pop_check(tag);
  endtask

  initial begin
    rst      = 1'b1;
    wready   = 1'b0;
    waddr    = '0;
    wdata    = '0;
    raddr    = '0;
    spins_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    rd(2'd1, 32'h0, "rst_status");
    rd(2'd3, 32'h0, "rst_result");
    rd(2'd2, 32'h0, "rst_run_cycles");
    rd(2'd0, 32'h0, "rst_ctrl");
    chk("rst_rstn", ising_rstn, 1'b0);
    chk("rst_start", start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    wr(2'd2, 32'd10);
    rd(2'd2, 32'd10, "run_cycles_rw");

    // First run: settle outputs immediately after the GO edge
    spins_in = 8'hA5;
    push_exp(10, 32'hA5);
    start_hi = 0;
    wr(2'd0, 32'h1);
    lat = 0;
    chk("settle_rstn", ising_rstn, 1'b1);
    chk("settle_start", start, 1'b0);
    chk("settle_busy", busy, 1'b1);
    step(SC - 1);
    chk("settle_end_start", start, 1'b0);
    step(1);
    chk("run_start", start, 1'b1);
    wait_done();
    pop_check("run10");
    chk("done_rstn", ising_rstn, 1'b0);
    chk("done_start", start, 1'b0);

    run_check(0, 8'h3C, 32'h1, "run0");

    // Abort five cycles into RUN
    spins_in = 8'hFF;
    wr(2'd2, 32'd10);
    wr(2'd0, 32'h1);
    lat = 0;
    step(SC);
    chk("abort_in_run", start, 1'b1);
    step(5);
    wr(2'd0, 32'h2);
    chk("abort_start", start, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_rstn", ising_rstn, 1'b0);
    rd(2'd3, 32'h3C, "abort_result");
    rd(2'd1, 32'h0, "abort_status");

    // GO while busy must not disturb timing
    spins_in = 8'h11;
    wr(2'd2, 32'd5);
    push_exp(5, 32'h11);
    start_hi = 0;
    wr(2'd0, 32'h1);
    lat = 0;
    step(3);
    wr(2'd0, 32'h1);
    lat++;
    step(5);
    wr(2'd0, 32'h1);
    lat++;
    wait_done();
    pop_check("go_busy");

    wr(2'd0, 32'h2);
    chk("abort_done_clr", done, 1'b0);
    rd(2'd1, 32'h0, "abort_idle_status");
    rd(2'd3, 32'h11, "abort_idle_result");

    wr(2'd0, 32'h3);
    chk("goabort_busy", busy, 1'b0);
    chk("goabort_rstn", ising_rstn, 1'b0);
    lat = 0;
    step(3);
    chk("goabort_stay", busy, 1'b0);
    rd(2'd1, 32'h0, "goabort_status");

    // Reset pulse mid-RUN
    wr(2'd2, 32'd10);
    wr(2'd0, 32'h1);
    lat = 0;
    step(SC + 3);
    chk("rst_mid_in_run", start, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstmid_rstn", ising_rstn, 1'b0);
    chk("rstmid_start", start, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_done", done, 1'b0);
    rd(2'd3, 32'h0, "rstmid_result");
    rd(2'd2, 32'h0, "rstmid_run_cycles");
    rd(2'd1, 32'h0, "rstmid_status");

`ifdef ISING_CTRL_IRQ_EN
    chk("rstmid_irq", irq, 1'b0);
    wr(2'd0, 32'h4);
    rd(2'd0, 32'h4, "irq_en_rd");
    irq_cnt = 0;
    irq_bad = 0;
    run_check(2, 8'h5A, 32'h5, "irq_run");
    step(3);
    chk("irq_pulses", irq_cnt, 1);
    chk("irq_align", irq_bad, 0);
    irq_cnt = 0;
    run_check(2, 8'h66, 32'h1, "noirq_run");
    step(3);
    chk("noirq_pulses", irq_cnt, 0);
`else
    wr(2'd0, 32'h4);
    rd(2'd0, 32'h0, "ctrl_bit2_ignored");
    chk("ctrl_bit2_idle", busy, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ising_run_ctrl.md
# ising_run_ctrl

Run controller for the coupled-cell Ising array. Owns the array-wide `ising_rstn` and `start` controls and sequences each anneal run: spin load, latch settle, free-running for a programmed cycle count, result capture. Sits between the AXI register slave and the cell array. Cell start spins are still written directly through each cell's own `wr_addr_match`; this block only arbitrates when those spins take effect and captures the result.

## Interface

Parameters:
- `NUM_SPINS`, default 8: number of spin outputs sampled. Range 1..32.
- `SETTLE_CYCLES`, default 4: cycles with `ising_rstn`=1 and `start`=0 before `start` rises. Range 1..255.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `wready`  in  1  write strobe; one write per cycle it is high.
- `waddr`  in  4  byte address of the write; bits [3:2] select the register.
- `wdata`  in  32  write data.
- `raddr`  in  4  read address, same decode as `waddr`.
- `rdata`  out  32  combinational read data for `raddr`.
- `spins_in`  in  NUM_SPINS  asynchronous cell outputs (`tout` of each cell).
- `ising_rstn`  out  1  array latch enable; low holds the cell latches closed.
- `start`  out  1  array run select; 0 drives stored spins, 1 closes the coupling loop.
- `busy`  out  1  run in progress.
- `done`  out  1  result valid.

## Operation

Registers, selected by `waddr[3:2]` / `raddr[3:2]`:
- 0 CTRL
  - Write bit0 = GO, bit1 = ABORT. Both are self-clearing pulses.
  - Reads as 0.
- 1 STATUS (read-only)
  - bit0 = busy, bit1 = done.
- 2 RUN_CYCLES (read/write, 32 bits)
  - Reset value 0. A value of 0 is treated as 1.
- 3 RESULT (read-only)
  - Bits [NUM_SPINS-1:0] hold the captured spins. Upper bits read 0.
  - Reset value 0.

State machine:
- IDLE: `ising_rstn`=0, `start`=0. On GO go to SETTLE and load the settle counter with SETTLE_CYCLES.
- SETTLE: `ising_rstn`=1, `start`=0. The counter decrements each cycle. At 1, go to RUN and load the run counter with max(RUN_CYCLES, 1).
- RUN: `ising_rstn`=1, `start`=1. The counter decrements each cycle. At 1, go to SYNC.
- SYNC: `ising_rstn`=1, `start`=1 for exactly 2 cycles while `spins_in` passes through a 2-flop synchronizer. Then capture RESULT and go to DONE.
- DONE: `ising_rstn`=0, `start`=0, `done`=1.
  - GO starts a new run: go to SETTLE and clear `done`.
  - Otherwise hold DONE.

Rules:
- `busy` = (state ∈ {SETTLE, RUN, SYNC}).
- GO while `busy` is ignored.
- ABORT while `busy`:
  - Next state IDLE.
  - `done` stays 0.
  - RESULT is unchanged.
- ABORT in IDLE or DONE:
  - Next state IDLE.
  - `done` is cleared.
- GO and ABORT in the same write: ABORT wins.
- A RUN_CYCLES write during a run does not affect the counter already loaded.

## Timing

- Reset values:
  - State IDLE.
  - `ising_rstn`=0, `start`=0, `busy`=0, `done`=0.
  - RESULT=0, RUN_CYCLES=0.
- Edge numbering: GO is written on edge T. SETTLE outputs appear after edge T.
- `start` rises after edge T+SETTLE_CYCLES.
- `start` stays high for max(RUN_CYCLES,1)+2 cycles.
- `done` rises on the same edge that RESULT is captured and `start` falls.
- Total latency from GO to `done` = SETTLE_CYCLES + max(RUN_CYCLES,1) + 2 cycles.
- `rst` asserted in any state: next edge forces the reset values above. Any in-progress run is lost.
- `rdata` is combinational from `raddr` and the register state. It has no wait states.

## Configuration

- `ISING_CTRL_IRQ_EN` defined:
  - Adds output `irq` (1 bit).
  - Adds CTRL bit2 = IRQ_ENABLE, read/write, reset 0. This bit is exempt from the "reads as 0" rule for CTRL.
  - `irq` pulses high for one cycle on the edge `done` rises, only if IRQ_ENABLE=1.
- Undefined:
  - No `irq` port.
  - CTRL bit2 is ignored and reads 0.

## Structure

- Shared package `ising_ctrl_pkg` holds:
  - State enum: IDLE, SETTLE, RUN, SYNC, DONE.
  - Register index constants: CTRL=0, STATUS=1, RUN_CYCLES=2, RESULT=3.
  - CTRL bit positions.
- One sub-module: `spin_sync`, a NUM_SPINS-wide 2-flop synchronizer for `spins_in`.

## Test plan

- Reset, then read all registers.
  - STATUS=0, RESULT=0, RUN_CYCLES=0.
  - `ising_rstn`=0, `start`=0.
- SETTLE_CYCLES=4, RUN_CYCLES=10, GO.
  - `start` is high for exactly 12 cycles.
  - `done` is set 16 cycles after the GO edge.
  - With `spins_in`=0xA5 held, RESULT=0xA5.
- RUN_CYCLES=0, GO.
  - `start` is high for 3 cycles.
  - `done` is set after SETTLE_CYCLES+3 cycles.
- ABORT 5 cycles into RUN.
  - Next cycle `start`=0, `busy`=0, `done`=0.
  - RESULT keeps its old value.
- GO while busy; GO and ABORT written together from IDLE.
  - The GO while busy has no effect on timing.
  - The combined write leaves the block in IDLE.
- `rst` pulsed mid-RUN.
  - All outputs return to reset values on the next edge.
- With `ISING_CTRL_IRQ_EN` defined and IRQ_ENABLE=1:
  - A single 1-cycle `irq` pulse coincides with `done` rising.
  - With IRQ_ENABLE=0, `irq` stays 0.
